unidad_logica_secuencial: RTL and testbench
===========================================

Name: unidad_logica_secuencial

Overview:
Parametrised successor to the combinational logic unit. Performs AND/OR/XOR/NOT in one cycle, and multi-cycle shifts and rotates: logical left/right, arithmetic right, rotate left/right, at one bit per clock. Operands are captured on a valid/ready handshake. The result is registered together with zero/negative/carry/invalid flags and held until the consumer accepts it. Sits in the ALU next to the arithmetic unit and feeds the ALU result mux and flag register.

Parameters:
N, 8, operand/result width; power of two, N >= 4.
W, $clog2(N), derived: width of the shift-amount field taken from operador2[W-1:0].

Ports:
clk  in  1  single system clock; all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
inicio  in  1  request valid; operands and opcode valid this cycle.
listo_entrada  out  1  block can accept a request this cycle.
operador1  in  N  data operand.
operador2  in  N  second operand (logic ops) / shift amount in bits [W-1:0] (upper bits ignored).
ALUControl  in  4  opcode (see Behaviour).
resultado  out  N  registered result.
valido_salida  out  1  resultado and flags are valid.
acepta_salida  in  1  consumer takes result this cycle.
cero  out  1  resultado == 0.
negativo  out  1  resultado[N-1].
acarreo  out  1  last bit shifted/rotated out; 0 otherwise.
invalido  out  1  opcode was unsupported.

Behaviour:
- Reset: synchronous, active-high on clk. State INACTIVO; resultado=0; valido_salida=0; cero, negativo, acarreo and invalido all 0. listo_entrada=1 after reset.
- Opcodes: 0 AND, 1 OR, 2 XOR, 3 NOT operador1, 4 SLL, 5 SRL, 6 SRA, 7 ROL, 8 ROR. Opcodes 9-15: resultado=0, invalido=1, cero=1, acarreo=0, latency 1.
- listo_entrada = (estado==INACTIVO) || (estado==LISTO && acepta_salida). Combinational.
- Accept = inicio && listo_entrada. On accept, capture operador1, opcode and k = operador2[W-1:0]; the logic result is computed from operador2 at accept. Later operand changes are ignored.
- FSM transitions:
  - INACTIVO --accept, logic/invalid op or k==0--> LISTO.
  - INACTIVO --accept, shift/rotate with k>0--> CORRIENDO; counter loaded with k.
  - CORRIENDO: one 1-bit shift/rotate of the working register per cycle; counter decrements; when it reaches 0 --> LISTO.
  - LISTO: valido_salida=1; outputs held stable. If acepta_salida=0, stay. If acepta_salida=1 with no accept --> INACTIVO. If acepta_salida=1 with accept --> next op (back-to-back, no bubble).
- Latency, measured from the accept edge to valido_salida high:
  - 1 cycle for logic ops, invalid opcodes and k==0.
  - k+1 cycles for shift/rotate with k>0.
- Shift rules (per step):
  - SLL fills 0 at LSB; SRL fills 0 at MSB; SRA replicates MSB.
  - ROL moves MSB to LSB; ROR moves LSB to MSB.
  - acarreo = bit leaving the register on the final step; 0 when k==0.
- Flags are registered together with resultado in the same cycle, with no skew.
- valido_salida is low in INACTIVO and CORRIENDO. resultado holds its previous value until LISTO is re-entered.
- Reset mid-operation (CORRIENDO or LISTO): next cycle is INACTIVO with all outputs 0; the in-flight result is discarded.
- inicio while busy (CORRIENDO, or LISTO without acepta_salida) is ignored. The requester must hold inicio until listo_entrada is high.

Test Plan:
1. N=8, AND 0xF0,0x3C accepted at cycle t -> valido_salida at t+1, resultado=0x30, cero=0, negativo=0, acarreo=0.
2. SRA 0x96 by k=2 -> valido_salida at t+3, resultado=0xE5, negativo=1, acarreo=1; listo_entrada low in between.
3. ROL 0xA5 by k=4 -> valido_salida at t+5, resultado=0x5A, acarreo=0. Then SRL 0xFF with operador2=0x08 (k=0) -> latency 1, resultado=0xFF, acarreo=0.
4. Backpressure: result XOR 0xFF,0xFF held with acepta_salida=0 for 3 cycles -> resultado=0x00, cero=1 stable, listo_entrada=0. Then acepta_salida=1 with inicio=1 (NOT 0x0F) -> accepted the same cycle, next cycle resultado=0xF0.
5. Invalid opcode 11 -> resultado=0, invalido=1, cero=1 after 1 cycle.
6. rst asserted during CORRIENDO of SLL 0x01 by 7 -> next cycle valido_salida=0, resultado=0, listo_entrada=1; a fresh request afterwards completes normally.

Source files
------------

// File: rtl/unidad_logica_secuencial.sv
// Logic unit: single-cycle AND/OR/XOR/NOT, bit-serial shifts/rotates,
// with a valid/ready handshake on both sides and a registered result plus flags.
module unidad_logica_secuencial #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inicio,
  output logic         listo_entrada,
  input  logic [N-1:0] operador1,
  input  logic [N-1:0] operador2,
  input  logic [3:0]   ALUControl,
  output logic [N-1:0] resultado,
  output logic         valido_salida,
  input  logic         acepta_salida,
  output logic         cero,
  output logic         negativo,
  output logic         acarreo,
  output logic         invalido
);

  typedef enum logic [1:0] {INACTIVO, CORRIENDO, LISTO} estado_t;

  estado_t        r_estado, w_estado_sig;
  logic [N-1:0]   r_trabajo;
  logic [W-1:0]   r_cont;
  logic [3:0]     r_op;
  logic [N-1:0]   r_resultado;
  logic           r_cero, r_negativo, r_acarreo, r_invalido;

  logic           w_listo, w_acepta, w_es_desp, w_largo, w_inm_inv, w_sale;
  logic [W-1:0]   w_k;
  logic [N-1:0]   w_inm_res, w_paso;

  assign w_listo   = (r_estado == INACTIVO) || ((r_estado == LISTO) && acepta_salida);
  assign w_acepta  = inicio && w_listo;
  assign w_k       = operador2[W-1:0];
  assign w_es_desp = (ALUControl >= 4'd4) && (ALUControl <= 4'd8);
  assign w_largo   = w_es_desp && (w_k != '0);

  // Result available on the accept edge: logic ops, invalid opcodes, zero-length shifts.
  always_comb begin
    w_inm_res = '0;
    w_inm_inv = 1'b0;
    case (ALUControl)
      4'd0:                         w_inm_res = operador1 & operador2;
      4'd1:                         w_inm_res = operador1 | operador2;
      4'd2:                         w_inm_res = operador1 ^ operador2;
      4'd3:                         w_inm_res = ~operador1;
      4'd4, 4'd5, 4'd6, 4'd7, 4'd8: w_inm_res = operador1;
      default:                      w_inm_inv = 1'b1;
    endcase
  end

  always_comb begin
    w_paso = r_trabajo;
    w_sale = 1'b0;
    case (r_op)
      4'd4: begin w_paso = {r_trabajo[N-2:0], 1'b0};          w_sale = r_trabajo[N-1]; end
      4'd5: begin w_paso = {1'b0, r_trabajo[N-1:1]};          w_sale = r_trabajo[0];   end
      4'd6: begin w_paso = {r_trabajo[N-1], r_trabajo[N-1:1]}; w_sale = r_trabajo[0];  end
      4'd7: begin w_paso = {r_trabajo[N-2:0], r_trabajo[N-1]}; w_sale = r_trabajo[N-1]; end
      4'd8: begin w_paso = {r_trabajo[0], r_trabajo[N-1:1]};   w_sale = r_trabajo[0];  end
      default: ;
    endcase
  end

  always_comb begin
    w_estado_sig = r_estado;
    case (r_estado)
      INACTIVO:  if (w_acepta) w_estado_sig = w_largo ? CORRIENDO : LISTO;
      CORRIENDO: if (r_cont == W'(1)) w_estado_sig = LISTO;
      LISTO: begin
        if (w_acepta)          w_estado_sig = w_largo ? CORRIENDO : LISTO;
        else if (acepta_salida) w_estado_sig = INACTIVO;
      end
      default:   w_estado_sig = INACTIVO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_estado <= INACTIVO;
    else     r_estado <= w_estado_sig;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_trabajo   <= '0;
      r_cont      <= '0;
      r_op        <= '0;
      r_resultado <= '0;
      r_cero      <= 1'b0;
      r_negativo  <= 1'b0;
      r_acarreo   <= 1'b0;
      r_invalido  <= 1'b0;
    end else if (w_acepta) begin
      r_trabajo <= operador1;
      r_cont    <= w_k;
      r_op      <= ALUControl;
      if (!w_largo) begin
        r_resultado <= w_inm_res;
        r_cero      <= (w_inm_res == '0);
        r_negativo  <= w_inm_res[N-1];
        r_acarreo   <= 1'b0;
        r_invalido  <= w_inm_inv;
      end
    end else if (r_estado == CORRIENDO) begin
      r_trabajo <= w_paso;
      r_cont    <= r_cont - W'(1);
      if (r_cont == W'(1)) begin
        r_resultado <= w_paso;
        r_cero      <= (w_paso == '0);
        r_negativo  <= w_paso[N-1];
        r_acarreo   <= w_sale;
        r_invalido  <= 1'b0;
      end
    end
  end

  assign listo_entrada = w_listo;
  assign valido_salida = (r_estado == LISTO);
  assign resultado     = r_resultado;
  assign cero          = r_cero;
  assign negativo      = r_negativo;
  assign acarreo       = r_acarreo;
  assign invalido      = r_invalido;

endmodule

// File: tb/tb_unidad_logica_secuencial.sv
// Directed + random scoreboard bench for unidad_logica_secuencial (N=8).
module tb_unidad_logica_secuencial;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst, inicio, acepta_salida;
  logic [N-1:0] operador1, operador2;
  logic [3:0]   ALUControl;
  logic         listo_entrada, valido_salida, cero, negativo, acarreo, invalido;
  logic [N-1:0] resultado;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    logic [N-1:0] res;
    logic         c, n, a, i;
    int           lat;
  } esperado_t;

  esperado_t q[$];

  unidad_logica_secuencial #(.N(N)) dut (
    .clk(clk), .rst(rst), .inicio(inicio), .listo_entrada(listo_entrada),
    .operador1(operador1), .operador2(operador2), .ALUControl(ALUControl),
    .resultado(resultado), .valido_salida(valido_salida),
    .acepta_salida(acepta_salida), .cero(cero), .negativo(negativo),
    .acarreo(acarreo), .invalido(invalido)
  );

  always #5 clk = ~clk;

  task automatic chequear(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic esperado_t modelo(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    esperado_t e;
    int k;
    k = int'(b[2:0]);
    e.res = '0; e.a = 1'b0; e.i = 1'b0; e.lat = 1;
    case (op)
      4'd0: e.res = a & b;
      4'd1: e.res = a | b;
      4'd2: e.res = a ^ b;
      4'd3: e.res = ~a;
      4'd4: begin e.res = a << k; if (k > 0) e.a = a[N-k]; end
      4'd5: begin e.res = a >> k; if (k > 0) e.a = a[k-1]; end
      4'd6: begin e.res = $signed(a) >>> k; if (k > 0) e.a = a[k-1]; end
      4'd7: begin e.res = (a << k) | (a >> (N-k)); if (k > 0) e.a = e.res[0]; end
      4'd8: begin e.res = (a >> k) | (a << (N-k)); if (k > 0) e.a = e.res[N-1]; end
      default: e.i = 1'b1;
    endcase
    if (op >= 4'd4 && op <= 4'd8 && k > 0) e.lat = k + 1;
    e.c = (e.res == '0);
    e.n = e.res[N-1];
    return e;
  endfunction

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic enviar(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    int t;
    t = 0;
    ALUControl = op; operador1 = a; operador2 = b; inicio = 1'b1;
    #1;
    while (!listo_entrada && t < 50) begin @(posedge clk); #1; t++; end
    chequear("listo_antes_de_enviar", {31'd0, listo_entrada}, 32'd1);
    q.push_back(modelo(op, a, b));
    @(posedge clk); #1;
    inicio = 1'b0;
    operador1 = N'($urandom); operador2 = N'($urandom); ALUControl = 4'($urandom);
  endtask

  task automatic recibir(input int espera, input bit liberar);
    esperado_t e;
    int c;
    c = 0;
    chequear("cola_no_vacia", {31'd0, q.size() != 0}, 32'd1);
    if (q.size() != 0) e = q.pop_front();
    else e = '{res: '0, c: 1'b0, n: 1'b0, a: 1'b0, i: 1'b0, lat: 0};
    do begin
      @(negedge clk); c++;
      if (!valido_salida) chequear("listo_ocupado", {31'd0, listo_entrada}, 32'd0);
    end while (!valido_salida && c < 60);
    chequear("latencia", c, e.lat);
    chequear("resultado", {24'd0, resultado}, {24'd0, e.res});
    chequear("cero", {31'd0, cero}, {31'd0, e.c});
    chequear("negativo", {31'd0, negativo}, {31'd0, e.n});
    chequear("acarreo", {31'd0, acarreo}, {31'd0, e.a});
    chequear("invalido", {31'd0, invalido}, {31'd0, e.i});
    for (int i = 0; i < espera; i++) begin
      @(negedge clk);
      chequear("mantiene_valido", {31'd0, valido_salida}, 32'd1);
      chequear("mantiene_resultado", {24'd0, resultado}, {24'd0, e.res});
      chequear("mantiene_cero", {31'd0, cero}, {31'd0, e.c});
      chequear("bloquea_entrada", {31'd0, listo_entrada}, 32'd0);
    end
    if (liberar) begin
      acepta_salida = 1'b1;
      @(posedge clk); #1;
      acepta_salida = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; inicio = 1'b0; acepta_salida = 1'b0;
    operador1 = '0; operador2 = '0; ALUControl = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chequear("rst_valido", {31'd0, valido_salida}, 32'd0);
    chequear("rst_resultado", {24'd0, resultado}, 32'd0);
    chequear("rst_listo", {31'd0, listo_entrada}, 32'd1);
    chequear("rst_flags", {28'd0, cero, negativo, acarreo, invalido}, 32'd0);

    enviar(4'd0, 8'hF0, 8'h3C); recibir(0, 1);
    enviar(4'd6, 8'h96, 8'h02); recibir(0, 1);
    enviar(4'd7, 8'hA5, 8'h04); recibir(0, 1);
    enviar(4'd5, 8'hFF, 8'h08); recibir(0, 1);

    // Held result, then accept + new request in the same cycle.
    enviar(4'd2, 8'hFF, 8'hFF); recibir(3, 0);
    acepta_salida = 1'b1; inicio = 1'b1;
    ALUControl = 4'd3; operador1 = 8'h0F; operador2 = 8'h00;
    q.push_back(modelo(4'd3, 8'h0F, 8'h00));
    #1;
    chequear("listo_back_to_back", {31'd0, listo_entrada}, 32'd1);
    @(posedge clk); #1;
    acepta_salida = 1'b0; inicio = 1'b0;
    recibir(0, 1);

    enviar(4'd11, 8'h5A, 8'hC3); recibir(0, 1);
    enviar(4'd4, 8'h81, 8'h07); recibir(1, 1);
    enviar(4'd8, 8'h01, 8'h01); recibir(0, 1);

    // Reset in the middle of a long shift.
    enviar(4'd4, 8'h01, 8'h07);
    repeat (3) @(negedge clk);
    chequear("corriendo_no_valido", {31'd0, valido_salida}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    chequear("rst_medio_valido", {31'd0, valido_salida}, 32'd0);
    chequear("rst_medio_resultado", {24'd0, resultado}, 32'd0);
    chequear("rst_medio_listo", {31'd0, listo_entrada}, 32'd1);
    chequear("rst_medio_flags", {28'd0, cero, negativo, acarreo, invalido}, 32'd0);
    enviar(4'd4, 8'h01, 8'h03); recibir(0, 1);

    for (int i = 0; i < 12; i++) begin
      enviar(4'($urandom_range(0, 9)), N'($urandom), N'($urandom));
      recibir(int'($urandom_range(0, 2)), 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
